imm_encode: RTL and testbench

- Inverse of the decode-stage immediate generator: packs a 32-bit immediate back into the instruction immediate fields for a given format.
- Merges the packed fields into a caller-supplied base instruction word and flags immediates that the format cannot represent.
- Used by the self-test/boot instruction builder and as the golden encoder in round-trip verification of the decoder.
- Two-stage valid/ready pipeline with full backpressure and a saturating error counter.

---
 rtl/imm_encode_if.sv | 33 +++
 rtl/imm_encode.sv | 171 +++++++++++++++++
 tb/tb_imm_encode.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_encode_if.sv
// imm_encode_if: valid/ready bundle between an immediate-encoder client and
// imm_encode. master = client side (drives requests, accepts results),
// slave = encoder side. Request: in_valid/in_ready, imm_type, imm,
// base_instr. Result: out_valid/out_ready, instr, err_*, err_count.
interface imm_encode_if #(
    parameter int IMM_WIDTH = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           imm_type;
    logic [IMM_WIDTH-1:0] imm;
    logic [IMM_WIDTH-1:0] base_instr;
    logic                 out_valid;
    logic                 out_ready;
    logic [IMM_WIDTH-1:0] instr;
    logic                 err_range;
    logic                 err_align;
    logic                 err_type;
    logic [CNT_WIDTH-1:0] err_count;

    modport master (
        output in_valid, imm_type, imm, base_instr, out_ready,
        input  in_ready, out_valid, instr,
        input  err_range, err_align, err_type, err_count
    );

    modport slave (
        input  in_valid, imm_type, imm, base_instr, out_ready,
        output in_ready, out_valid, instr,
        output err_range, err_align, err_type, err_count
    );
endinterface

// File: rtl/imm_encode.sv
// imm_encode: packs a 32-bit immediate into the immediate fields of a base
// instruction word for a given format and flags unrepresentable values.
// Ports: clk; rst (synchronous, active-high); bus (imm_encode_if.slave):
//   in_valid/in_ready, imm_type, imm, base_instr  -> stage 1 (checks)
//   out_valid/out_ready, instr, err_*, err_count  <- stage 2 (registered)
// Format codes: R=0 I=1 S=2 SB=3 U=4 UJ=5; 6 and 7 are undefined.
module imm_encode #(
    parameter int IMM_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    imm_encode_if.slave bus
);
    localparam logic [2:0] R_TYPE  = 3'd0;
    localparam logic [2:0] I_TYPE  = 3'd1;
    localparam logic [2:0] S_TYPE  = 3'd2;
    localparam logic [2:0] SB_TYPE = 3'd3;
    localparam logic [2:0] U_TYPE  = 3'd4;
    localparam logic [2:0] UJ_TYPE = 3'd5;

    logic                 s1_valid_q, s1_valid_d;
    logic [2:0]           s1_type_q, s1_type_d;
    logic [IMM_WIDTH-1:0] s1_imm_q, s1_imm_d;
    logic [IMM_WIDTH-1:0] s1_base_q, s1_base_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [IMM_WIDTH-1:0] instr_q, instr_d;
    logic                 err_range_q, err_range_d;
    logic                 err_align_q, err_align_d;
    logic                 err_type_q, err_type_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

    logic                 s2_load;
    logic                 in_ready;
    logic                 accept;
    logic                 out_fire;
    logic [IMM_WIDTH-1:0] pack;
    logic                 rng;
    logic                 aln;
    logic                 typ;

    // Stage 2 refills whenever it is empty or draining this cycle, so a
    // stream under constant out_ready never bubbles.
    assign s2_load  = s1_valid_q && (!s2_valid_q || bus.out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign accept   = bus.in_valid && in_ready;
    assign out_fire = s2_valid_q && bus.out_ready;

    // Field packing and checks on the registered stage-1 operands.
    // A field "fits" when the bits above its sign bit are all equal.
    always_comb begin
        pack = s1_base_q;
        rng  = 1'b0;
        aln  = 1'b0;
        typ  = 1'b0;
        case (s1_type_q)
            R_TYPE: begin
                pack = s1_base_q;
            end
            I_TYPE: begin
                pack[31:20] = s1_imm_q[11:0];
                rng = !(&s1_imm_q[31:11] || !(|s1_imm_q[31:11]));
            end
            S_TYPE: begin
                pack[31:25] = s1_imm_q[11:5];
                pack[11:7]  = s1_imm_q[4:0];
                rng = !(&s1_imm_q[31:11] || !(|s1_imm_q[31:11]));
            end
            SB_TYPE: begin
                pack[31]    = s1_imm_q[12];
                pack[30:25] = s1_imm_q[10:5];
                pack[11:8]  = s1_imm_q[4:1];
                pack[7]     = s1_imm_q[11];
                rng = !(&s1_imm_q[31:12] || !(|s1_imm_q[31:12]));
                aln = s1_imm_q[0];
            end
            U_TYPE: begin
                pack[31:12] = s1_imm_q[31:12];
                rng = |s1_imm_q[11:0];
            end
            UJ_TYPE: begin
                pack[31]    = s1_imm_q[20];
                pack[30:21] = s1_imm_q[10:1];
                pack[20]    = s1_imm_q[11];
                pack[19:12] = s1_imm_q[19:12];
                rng = !(&s1_imm_q[31:20] || !(|s1_imm_q[31:20]));
                aln = s1_imm_q[0];
            end
            default: begin
                pack = s1_base_q;
                typ  = 1'b1;
            end
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_type_d  = s1_type_q;
        s1_imm_d   = s1_imm_q;
        s1_base_d  = s1_base_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_type_d  = bus.imm_type;
            s1_imm_d   = bus.imm;
            s1_base_d  = bus.base_instr;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        instr_d     = instr_q;
        err_range_d = err_range_q;
        err_align_d = err_align_q;
        err_type_d  = err_type_q;
        if (s2_load) begin
            s2_valid_d  = 1'b1;
            instr_d     = pack;
            err_range_d = rng;
            err_align_d = aln;
            err_type_d  = typ;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    // Saturating count of flagged results actually handed downstream.
    always_comb begin
        err_count_d = err_count_q;
        if (out_fire && (err_range_q || err_align_q || err_type_q)
            && !(&err_count_q)) begin
            err_count_d = err_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_type_q   <= '0;
            s1_imm_q    <= '0;
            s1_base_q   <= '0;
            s2_valid_q  <= 1'b0;
            instr_q     <= '0;
            err_range_q <= 1'b0;
            err_align_q <= 1'b0;
            err_type_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_type_q   <= s1_type_d;
            s1_imm_q    <= s1_imm_d;
            s1_base_q   <= s1_base_d;
            s2_valid_q  <= s2_valid_d;
            instr_q     <= instr_d;
            err_range_q <= err_range_d;
            err_align_q <= err_align_d;
            err_type_q  <= err_type_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.instr     = instr_q;
    assign bus.err_range = err_range_q;
    assign bus.err_align = err_align_q;
    assign bus.err_type  = err_type_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_imm_encode.sv
// tb_imm_encode: bench for imm_encode with a field-level encoder/decoder
// model, directed literal cases, backpressure, reset and random traffic.
`timescale 1ns/1ps
module tb_imm_encode;
    localparam int W    = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [2:0] T_R  = 3'd0;
    localparam logic [2:0] T_I  = 3'd1;
    localparam logic [2:0] T_S  = 3'd2;
    localparam logic [2:0] T_SB = 3'd3;
    localparam logic [2:0] T_U  = 3'd4;
    localparam logic [2:0] T_UJ = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_encode_if #(.IMM_WIDTH(W), .CNT_WIDTH(CW)) bus ();
    imm_encode #(.IMM_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [2:0]  t;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        rng;
        logic        aln;
        logic        typ;
    } exp_t;

    exp_t        q[$];
    logic [31:0] out_log[$];
    int          checks = 0;
    int          errors = 0;
    int          n_out = 0;
    int          rt_n = 0;
    int          cnt_m = 0;
    bit          saw_stall = 0;
    bit          done = 0;
    logic [31:0] last_instr;
    logic [2:0]  last_f;
    logic        held_v = 1'b0;
    logic [31:0] held_instr;
    logic [2:0]  held_f;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endfunction

    // Encoder model: ranges stated as signed intervals.
    function automatic exp_t model(logic [2:0] t, logic [31:0] i,
                                   logic [31:0] b);
        exp_t e;
        int s;
        s = $signed(i);
        e.t = t; e.imm = i; e.instr = b;
        e.rng = 1'b0; e.aln = 1'b0; e.typ = 1'b0;
        case (t)
            T_R: e.instr = b;
            T_I: begin
                e.instr[31:20] = i[11:0];
                e.rng = (s < -2048) || (s > 2047);
            end
            T_S: begin
                e.instr[31:25] = i[11:5];
                e.instr[11:7] = i[4:0];
                e.rng = (s < -2048) || (s > 2047);
            end
            T_SB: begin
                e.instr[31] = i[12];
                e.instr[30:25] = i[10:5];
                e.instr[11:8] = i[4:1];
                e.instr[7] = i[11];
                e.rng = (s < -4096) || (s > 4095);
                e.aln = i[0];
            end
            T_U: begin
                e.instr[31:12] = i[31:12];
                e.rng = (i & 32'hFFF) != 0;
            end
            T_UJ: begin
                e.instr[31] = i[20];
                e.instr[30:21] = i[10:1];
                e.instr[20] = i[11];
                e.instr[19:12] = i[19:12];
                e.rng = (s < -(1 << 20)) || (s > (1 << 20) - 1);
                e.aln = i[0];
            end
            default: e.typ = 1'b1;
        endcase
        return e;
    endfunction

    // Decode-stage immediate generator.
    function automatic logic [31:0] decode(logic [2:0] t, logic [31:0] x);
        case (t)
            T_I:  return {{20{x[31]}}, x[31:20]};
            T_S:  return {{20{x[31]}}, x[31:25], x[11:7]};
            T_SB: return {{19{x[31]}}, x[31], x[7], x[30:25],
                          x[11:8], 1'b0};
            T_U:  return {x[31:12], 12'h000};
            T_UJ: return {{11{x[31]}}, x[31], x[19:12], x[20],
                          x[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] legal_imm(logic [2:0] t);
        logic [31:0] r;
        r = $urandom;
        case (t)
            T_I, T_S: return {{20{r[11]}}, r[11:0]};
            T_SB:     return {{19{r[12]}}, r[12:1], 1'b0};
            T_U:      return {r[31:12], 12'h000};
            T_UJ:     return {{11{r[20]}}, r[20:1], 1'b0};
            default:  return r;
        endcase
    endfunction

    // Compare process: samples 1ns after the falling edge, i.e. the
    // handshakes it sees are those taken on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        logic [2:0] f;
        #1;
        if (rst) begin
            q.delete();
            cnt_m  = 0;
            held_v = 1'b0;
        end else begin
            f = {bus.err_range, bus.err_align, bus.err_type};
            chk("err_count", 32'(bus.err_count), 32'(cnt_m));
            if (held_v) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_instr", bus.instr, held_instr);
                chk("stall_flags", 32'(f), 32'(held_f));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: instr 0x%08h", bus.instr);
                end else begin
                    e = q.pop_front();
                    chk("instr", bus.instr, e.instr);
                    chk("flags", 32'(f), 32'({e.rng, e.aln, e.typ}));
                    if (!(e.rng || e.aln || e.typ) && e.t != T_R) begin
                        chk("roundtrip", decode(e.t, bus.instr), e.imm);
                        rt_n++;
                    end
                    if ((e.rng || e.aln || e.typ) && cnt_m < CMAX)
                        cnt_m++;
                    out_log.push_back(e.imm);
                    last_instr = bus.instr;
                    last_f = f;
                    n_out++;
                end
            end
            held_v = bus.out_valid && !bus.out_ready;
            held_instr = bus.instr;
            held_f = f;
            if (bus.in_valid && !bus.in_ready) saw_stall = 1;
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.imm_type, bus.imm, bus.base_instr));
        end
    end

    // Called at a falling edge; returns at the falling edge after the
    // transfer, with in_valid still high.
    task automatic send(logic [2:0] t, logic [31:0] i, logic [31:0] b);
        int k;
        k = 0;
        bus.in_valid = 1'b1;
        bus.imm_type = t;
        bus.imm = i;
        bus.base_instr = b;
        #2;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready 0 want 1");
        end
        @(negedge clk);
    endtask

    task automatic xact(logic [2:0] t, logic [31:0] i, logic [31:0] b);
        int n0;
        int k;
        n0 = n_out;
        k = 0;
        send(t, i, b);
        bus.in_valid = 1'b0;
        forever begin
            #3;
            if (n_out != n0 || k >= 20) break;
            @(negedge clk);
            k++;
        end
        if (n_out == n0) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: no output want 1");
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus.in_valid = 1'b0;
        while ((q.size() != 0 || bus.out_valid) && k < 100) begin
            @(negedge clk);
            #3;
            k++;
        end
        chk("drained", 32'(q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] t;
        logic [31:0] i;
        int n0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.imm_type = '0;
        bus.imm = '0;
        bus.base_instr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_count", 32'(bus.err_count), 32'd0);
        chk("rst_flags", 32'({bus.err_range, bus.err_align, bus.err_type}),
            32'd0);
        @(negedge clk);

        xact(T_I, 32'hFFFFF800, 32'h00000013);
        chk("i_neg", last_instr, 32'h80000013);
        chk("i_neg_f", 32'(last_f), 32'd0);
        xact(T_I, 32'h00000800, 32'h00000013);
        chk("i_rng_f", 32'(last_f), 32'b100);
        chk("i_rng_cnt", 32'(bus.err_count), 32'd1);
        xact(T_SB, 32'hFFFFFFFC, 32'h00000063);
        chk("sb_neg", last_instr, 32'hFE000EE3);
        chk("sb_neg_f", 32'(last_f), 32'd0);
        xact(T_SB, 32'h00000006, 32'h00000063);
        chk("sb_6", last_instr, 32'h00000363);
        chk("sb_6_f", 32'(last_f), 32'd0);
        xact(T_SB, 32'h00000005, 32'h00000063);
        chk("sb_5", last_instr, 32'h00000263);
        chk("sb_5_f", 32'(last_f), 32'b010);
        xact(T_UJ, 32'h000FFFFE, 32'h0000006F);
        chk("uj", last_instr, 32'h7FFFF06F);
        chk("uj_f", 32'(last_f), 32'd0);
        xact(T_U, 32'h12345001, 32'h00000037);
        chk("u_hi", last_instr >> 12, 32'h00012345);
        chk("u_f", 32'(last_f), 32'b100);
        xact(3'd7, 32'h00000123, 32'hDEADBEEF);
        chk("bad_t", last_instr, 32'hDEADBEEF);
        chk("bad_t_f", 32'(last_f), 32'b001);
        chk("dir_cnt", 32'(bus.err_count), 32'd4);

        out_log.delete();
        saw_stall = 0;
        fork
            begin
                for (int v = 1; v <= 6; v++)
                    send(T_I, 32'(v), 32'h00000013);
                bus.in_valid = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (4) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_stall", 32'(saw_stall), 32'd1);
        chk("bp_count", 32'(out_log.size()), 32'd6);
        for (int k = 0; k < out_log.size(); k++)
            chk("bp_order", out_log[k], 32'(k + 1));

        done = 0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    t = 3'($urandom_range(0, 5));
                    if ($urandom_range(0, 19) == 0)
                        t = 3'($urandom_range(6, 7));
                    i = legal_imm(t);
                    if ($urandom_range(0, 9) == 0) i = $urandom;
                    send(t, i, $urandom);
                    if ($urandom_range(0, 4) == 0) begin
                        bus.in_valid = 1'b0;
                        @(negedge clk);
                    end
                end
                bus.in_valid = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("rt_seen", 32'(rt_n > 0), 32'd1);

        bus.out_ready = 1'b0;
        send(T_I, 32'd7, 32'h00000013);
        send(T_U, 32'h00000801, 32'h00000037);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("full_valid", 32'(bus.out_valid), 32'd1);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        n0 = n_out;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_cnt", 32'(bus.err_count), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        repeat (4) @(negedge clk);
        chk("mid_rst_drop", 32'(n_out), 32'(n0));

        for (int n = 0; n < CMAX + 4; n++) begin
            if (n % 2 == 0) send(3'd7, 32'h0, 32'h13);
            else send(T_I, 32'h00000800, 32'h13);
        end
        drain();
        chk("sat_cnt", 32'(bus.err_count), 32'h0000000F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
